// File: rtl/alu_operand_sequencer.sv
// Board front end for the ALU: debounced push-buttons load A, B and the opcode in order,
// then the triple is offered with valid/ready. Build option: ALU_SEQ_OPERAND_HOLD_EN.

module alu_seq_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2;
  logic          r_deb, r_deb_q;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb & ~r_deb_q;
      // Any sample that agrees with the debounced level restarts the stability window.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;
endmodule

module alu_operand_sequencer #(
  parameter int N               = 8,
  parameter int N_OP            = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                input_clock,
  input  logic                input_reset,
  input  logic signed [N-1:0] input_switches,
  input  logic [2:0]          input_buttons,
  input  logic                input_ready,
  output logic signed [N-1:0] output_a,
  output logic signed [N-1:0] output_b,
  output logic [N_OP-1:0]     output_op,
  output logic                output_valid,
  output logic [1:0]          output_state
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HAVE_A  = 2'd1,
    S_HAVE_AB = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

`ifdef ALU_SEQ_OPERAND_HOLD_EN
  localparam state_t S_AFTER_HS = S_HAVE_AB;
`else
  localparam state_t S_AFTER_HS = S_IDLE;
`endif

  logic [2:0] w_press;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_btn
      alu_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .i_clk   (input_clock),
        .i_rst_n (input_reset),
        .i_btn   (input_buttons[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  state_t              r_state;
  logic signed [N-1:0] r_a, r_b;
  logic [N_OP-1:0]     r_op;
  logic                r_valid;

  always_ff @(posedge input_clock) begin
    if (!input_reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press[0]) begin
            r_a     <= input_switches;
            r_state <= S_HAVE_A;
          end
        end
        S_HAVE_A: begin
          if (w_press[1]) begin
            r_b     <= input_switches;
            r_state <= S_HAVE_AB;
          end else if (w_press[0]) begin
            r_a <= input_switches;
          end
        end
        S_HAVE_AB: begin
          if (w_press[2]) begin
            r_op    <= input_switches[N_OP-1:0];
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else if (w_press[1]) begin
            r_b <= input_switches;
          end else if (w_press[0]) begin
            r_a     <= input_switches;
            r_state <= S_HAVE_A;
          end
        end
        S_ISSUE: begin
          // Operands frozen until the ALU takes them; presses are dropped.
          if (input_ready) begin
            r_valid <= 1'b0;
            r_state <= S_AFTER_HS;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign output_a     = r_a;
  assign output_b     = r_b;
  assign output_op    = r_op;
  assign output_valid = r_valid;
  assign output_state = r_state;
endmodule
